aes128_decrypt: RTL



---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_inv_sbox.sv | 26 ++
 rtl/aes_sbox.sv | 27 ++
 rtl/aes128_decrypt.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the encrypt and decrypt cores: the control FSM
// state encoding, block/word/byte widths, the round-constant table and the
// GF(2^8) / byte-permutation helpers used by the round datapaths.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        KEY_FWD,
        ARK,
        ISR,
        ISB,
        IMC,
        DONE
    } aes_state_e;

    // Round constants RCON[1..10]; any other index returns 0.
    function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General multiply by a 4-bit constant (used with 9, 11, 13, 14).
    function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] b,
                                               input logic [3:0]        m);
        logic [BYTE_W-1:0] x2, x4, x8, r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = '0;
        if (m[0]) r = r ^ b;
        if (m[1]) r = r ^ x2;
        if (m[2]) r = r ^ x4;
        if (m[3]) r = r ^ x8;
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte (row r, column c) sits at bits [127 - 8*(4c + r) -: 8].
    // Row r rotates right by r byte positions.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1 - 8*(4*c + row) -: 8] =
                    s[BLOCK_W-1 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox
// Inverse AES S-box, purely combinational 256-entry lookup.
// Ports: idx - input byte, val - inverse-substituted byte.
// ---------------------------------------------------------------------------
module aes_inv_sbox (
    input  logic [7:0] idx,
    output logic [7:0] val
);

    localparam logic [2047:0] TABLE = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
    };

    logic [10:0] sel;
    assign sel = ~{idx, 3'b000};
    assign val = TABLE[sel -: 8];

endmodule

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational 256-entry lookup.
// Ports: idx - input byte, val - substituted byte.
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] idx,
    output logic [7:0] val
);

    localparam logic [2047:0] TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    // Entry k occupies bits [2047 - 8k -: 8]; ~{k,000} is exactly 2047 - 8k.
    logic [10:0] sel;
    assign sel = ~{idx, 3'b000};
    assign val = TABLE[sel -: 8];

endmodule

// File: rtl/aes128_decrypt.sv
// ---------------------------------------------------------------------------
// aes128_decrypt
// Iterative AES-128 inverse cipher. On start the master key is expanded
// forward to round key 10, then ten inverse rounds run while the key
// schedule is walked backwards one round key at a time.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request, sampled only while idle
//   ciphertext - 128-bit input block, byte 0 in bits [127:120]
//   master_key - 128-bit cipher key, same byte order
//   plaintext  - result register, held until the next completion
//   done       - one-cycle pulse when plaintext is updated
//   busy       - high whenever the core is not idle
//
// Build option AES_DEC_KEY_CACHE_EN: remembers the last master key and its
// round key 10 so a repeated key skips the forward expansion (70 vs 80
// cycles from start to done).
// ---------------------------------------------------------------------------
module aes128_decrypt
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] ciphertext,
    input  logic [BLOCK_W-1:0] master_key,
    output logic [BLOCK_W-1:0] plaintext,
    output logic               done,
    output logic               busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_state_e         fsm;
    logic [3:0]         cnt;
    logic [3:0]         round;
    logic [BLOCK_W-1:0] state;
    logic [BLOCK_W-1:0] rk;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [BLOCK_W-1:0] cache_key;
    logic [BLOCK_W-1:0] cache_k10;
    logic               cache_vld;
`endif

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        logic [BYTE_W-1:0]  a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[BLOCK_W-1 - WORD_W*c -: WORD_W];
            r[BLOCK_W-1 - WORD_W*c -: WORD_W] = {
                gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
        end
        return r;
    endfunction

    // Key schedule: forward and inverse steps share one SubWord. Forward
    // feeds RotWord(w3); inverse needs RotWord of the recovered w3' = w3^w2.
    logic [WORD_W-1:0]  w0, w1, w2, w3, w3_prev;
    logic [WORD_W-1:0]  sb_in, sb_out, g_word;
    logic [WORD_W-1:0]  f0, f1, f2, f3;
    logic [BYTE_W-1:0]  rc;
    logic [BLOCK_W-1:0] rk_fwd, rk_inv;

    assign {w0, w1, w2, w3} = rk;
    assign w3_prev = w3 ^ w2;
    assign sb_in   = rot_word((fsm == KEY_FWD) ? w3 : w3_prev);
    assign rc      = rcon((fsm == KEY_FWD) ? cnt + 4'd1 : round);
    assign g_word  = sb_out ^ {rc, 24'h000000};

    assign f0     = w0 ^ g_word;
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};
    assign rk_inv = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, w3_prev};

    // InvSubBytes works on one column per cycle, selected by cnt.
    logic [WORD_W-1:0]  col_in, col_out;
    logic [BLOCK_W-1:0] state_isb;

    always_comb begin
        col_in    = state[127:96];
        state_isb = state;
        case (cnt[1:0])
            2'd0: begin col_in = state[127:96]; state_isb[127:96] = col_out; end
            2'd1: begin col_in = state[95:64];  state_isb[95:64]  = col_out; end
            2'd2: begin col_in = state[63:32];  state_isb[63:32]  = col_out; end
            default: begin col_in = state[31:0]; state_isb[31:0] = col_out; end
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .idx (sb_in[8*i +: 8]),
            .val (sb_out[8*i +: 8])
        );
        aes_inv_sbox u_inv_sbox (
            .idx (col_in[8*i +: 8]),
            .val (col_out[8*i +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            round     <= '0;
            state     <= '0;
            rk        <= '0;
            plaintext <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key <= '0;
            cache_k10 <= '0;
            cache_vld <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state <= ciphertext;
                        cnt   <= '0;
                        round <= LAST_ROUND;
                        busy  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                        if (cache_vld && (master_key == cache_key)) begin
                            rk  <= cache_k10;
                            fsm <= ARK;
                        end else begin
                            rk        <= master_key;
                            cache_key <= master_key;
                            cache_vld <= 1'b0;
                            fsm       <= KEY_FWD;
                        end
`else
                        rk  <= master_key;
                        fsm <= KEY_FWD;
`endif
                    end
                end
                KEY_FWD: begin
                    rk <= rk_fwd;
                    if (cnt == LAST_ROUND - 4'd1) begin
                        cnt <= '0;
                        fsm <= ARK;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_k10 <= rk_fwd;
                        cache_vld <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ARK: begin
                    state <= state ^ rk;
                    if (round == 4'd0) begin
                        // Result is published on entry to DONE so done and
                        // plaintext change on the same edge.
                        plaintext <= state ^ rk;
                        done      <= 1'b1;
                        fsm       <= DONE;
                    end else if (round == LAST_ROUND) begin
                        fsm <= ISR;
                    end else begin
                        fsm <= IMC;
                    end
                end
                IMC: begin
                    state <= inv_mix_columns(state);
                    fsm   <= ISR;
                end
                ISR: begin
                    state <= inv_shift_rows(state);
                    fsm   <= ISB;
                end
                ISB: begin
                    state <= state_isb;
                    if (cnt == 4'd3) begin
                        rk    <= rk_inv;
                        round <= round - 4'd1;
                        cnt   <= '0;
                        fsm   <= ARK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule
